// File: rtl/time_entry_keypad.sv
// Keypad debouncer and M:SS entry buffer feeding the MS timer.
// Issues a one-cycle active-low load strobe once a valid entry is started.
module time_entry_keypad #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [9:0] keypad,
  input  logic       start,
  input  logic       clear,
  input  logic       timer_done,
  output logic [3:0] min_data,
  output logic [3:0] tens_data,
  output logic [3:0] secs_data,
  output logic       loadn,
  output logic       running,
  output logic [1:0] digit_cnt,
  output logic       entry_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [3:0] LP_DB = 4'(DEBOUNCE_CYCLES);

  state_t     r_state, w_state_nxt;
  logic [9:0] r_prev;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_latch, w_latch_nxt;
  logic [3:0] r_min, w_min_nxt;
  logic [3:0] r_tens, w_tens_nxt;
  logic [3:0] r_secs, w_secs_nxt;
  logic [1:0] r_dcnt, w_dcnt_nxt;
  logic       r_loadn, w_loadn_nxt;
  logic       r_run, w_run_nxt;
  logic       r_err, w_err_nxt;

  logic [3:0] w_nbits;
  logic [3:0] w_key;
  logic       w_valid;
  logic       w_zero;
  logic       w_same;
  logic       w_accept;
  logic       w_release;
  logic       w_shift;

  always_comb begin
    w_nbits = '0;
    w_key   = '0;
    for (int k = 0; k < 10; k++) begin
      if (keypad[k]) begin
        w_nbits = w_nbits + 4'd1;
        w_key   = 4'(k);
      end
    end
  end

  assign w_valid = (w_nbits == 4'd1);
  assign w_zero  = (keypad == '0);
  assign w_same  = (keypad == r_prev);

  // One counter times both a stable key and a stable all-zero release.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_same && (w_valid || w_zero)) begin
      w_cnt_nxt = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    end
  end

  assign w_accept  = w_valid && !r_latch
                  && (w_cnt_nxt >= LP_DB);
  assign w_release = w_zero && (w_cnt_nxt >= LP_DB);

  always_comb begin
    w_latch_nxt = r_latch;
    if (w_accept) begin
      w_latch_nxt = 1'b1;
    end else if (w_release) begin
      w_latch_nxt = 1'b0;
    end
  end

  // After a rejected start a new digit may shift the full buffer along.
  assign w_shift = w_accept && ((r_dcnt != 2'd3) || r_err);

  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_tens_nxt  = r_tens;
    w_secs_nxt  = r_secs;
    w_dcnt_nxt  = r_dcnt;
    w_loadn_nxt = 1'b1;
    w_run_nxt   = 1'b0;
    w_err_nxt   = r_err;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_min_nxt   = '0;
      w_tens_nxt  = '0;
      w_secs_nxt  = '0;
      w_dcnt_nxt  = '0;
      w_err_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_ENTRY: begin
          if (w_shift) begin
            w_min_nxt   = r_tens;
            w_tens_nxt  = r_secs;
            w_secs_nxt  = w_key;
            if (r_dcnt != 2'd3) begin
              w_dcnt_nxt = r_dcnt + 2'd1;
            end
            w_state_nxt = S_ENTRY;
            w_err_nxt   = 1'b0;
          end else if (start && (r_dcnt != 2'd0)) begin
            if (r_tens > 4'd5) begin
              w_state_nxt = S_ENTRY;
              w_err_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_LOAD;
              w_loadn_nxt = 1'b0;
              w_err_nxt   = 1'b0;
            end
          end
        end
        S_LOAD: begin
          w_state_nxt = S_RUN;
          w_run_nxt   = 1'b1;
        end
        S_RUN: begin
          if (timer_done) begin
            w_state_nxt = S_IDLE;
            w_min_nxt   = '0;
            w_tens_nxt  = '0;
            w_secs_nxt  = '0;
            w_dcnt_nxt  = '0;
          end else begin
            w_run_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_latch <= 1'b0;
      r_min   <= '0;
      r_tens  <= '0;
      r_secs  <= '0;
      r_dcnt  <= '0;
      r_loadn <= 1'b1;
      r_run   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= keypad;
      r_cnt   <= w_cnt_nxt;
      r_latch <= w_latch_nxt;
      r_min   <= w_min_nxt;
      r_tens  <= w_tens_nxt;
      r_secs  <= w_secs_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_loadn <= w_loadn_nxt;
      r_run   <= w_run_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign min_data  = r_min;
  assign tens_data = r_tens;
  assign secs_data = r_secs;
  assign loadn     = r_loadn;
  assign running   = r_run;
  assign digit_cnt = r_dcnt;
  assign entry_err = r_err;

endmodule

// File: tb/tb_time_entry_keypad.sv
// Directed bench for time_entry_keypad with a cycle-level entry model.
// Outputs are compared against the model on every falling edge.
module tb_time_entry_keypad;

  localparam int DB = 4;

  logic       clock;
  logic       clrn;
  logic [9:0] keypad;
  logic       start;
  logic       clear;
  logic       timer_done;
  logic [3:0] min_data;
  logic [3:0] tens_data;
  logic [3:0] secs_data;
  logic       loadn;
  logic       running;
  logic [1:0] digit_cnt;
  logic       entry_err;

  int checks = 0;
  int errors = 0;
  bit en = 0;

  time_entry_keypad #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock      (clock),
    .clrn       (clrn),
    .keypad     (keypad),
    .start      (start),
    .clear      (clear),
    .timer_done (timer_done),
    .min_data   (min_data),
    .tens_data  (tens_data),
    .secs_data  (secs_data),
    .loadn      (loadn),
    .running    (running),
    .digit_cnt  (digit_cnt),
    .entry_err  (entry_err)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Model: run length of identical keypad samples, digit list, phase.
  // Phase: 0 idle, 1 entry, 2 load strobe, 3 running.
  int m_last = 0;
  int m_rl = 1;
  bit m_latch = 0;
  int m_min = 0, m_tens = 0, m_secs = 0, m_n = 0;
  int m_phase = 0;
  bit m_err = 0;
  int s;
  bit stable, acc;

  always @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      m_last = 0; m_rl = 1; m_latch = 0;
      m_min = 0; m_tens = 0; m_secs = 0; m_n = 0;
      m_phase = 0; m_err = 0;
    end else begin
      s = int'(keypad);
      if (s == m_last) m_rl++;
      else m_rl = 1;
      m_last = s;
      stable = (m_rl > DB);
      acc = ($countones(keypad) == 1) && stable && !m_latch;
      if (acc) m_latch = 1;
      else if (s == 0 && stable) m_latch = 0;
      if (clear) begin
        m_min = 0; m_tens = 0; m_secs = 0; m_n = 0;
        m_phase = 0; m_err = 0;
      end else if (m_phase <= 1) begin
        if (acc && (m_n < 3 || m_err)) begin
          m_min = m_tens; m_tens = m_secs; m_secs = $clog2(s);
          if (m_n < 3) m_n++;
          m_phase = 1; m_err = 0;
        end else if (start && m_n > 0) begin
          if (m_tens > 5) m_err = 1;
          else m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 3;
      end else if (timer_done) begin
        m_min = 0; m_tens = 0; m_secs = 0; m_n = 0;
        m_phase = 0;
      end
    end
  end

  logic [16:0] act_v, exp_v;
  always @(negedge clock) begin
    if (en) begin
      act_v = {min_data, tens_data, secs_data, loadn,
               running, digit_cnt, entry_err};
      exp_v = {4'(m_min), 4'(m_tens), 4'(m_secs),
               m_phase != 2, m_phase == 3, 2'(m_n), m_err};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model t=%0t got %h want %h",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(int k, int hold, int rel);
    keypad = 10'(1 << k);
    cyc(hold);
    keypad = '0;
    cyc(rel);
  endtask

  task automatic pulse_clear();
    clear = 1;
    cyc(1);
    clear = 0;
  endtask

  initial begin
    keypad = '0; start = 0; clear = 0; timer_done = 0;
    clrn = 1;
    #1 clrn = 0;
    en = 1;
    cyc(2);
    clrn = 1;
    chk("rst_loadn", int'(loadn), 1);
    chk("rst_cnt", int'(digit_cnt), 0);
    chk("rst_run", int'(running), 0);

    // Entry 1:30 and a full load/run/done cycle.
    press(1, 6, 6);
    press(3, 6, 6);
    press(0, 6, 6);
    chk("e_min", int'(min_data), 1);
    chk("e_tens", int'(tens_data), 3);
    chk("e_secs", int'(secs_data), 0);
    chk("e_cnt", int'(digit_cnt), 3);
    chk("e_loadn", int'(loadn), 1);
    start = 1;
    cyc(1);
    start = 0;
    chk("ld_low", int'(loadn), 0);
    chk("ld_tens", int'(tens_data), 3);
    cyc(1);
    chk("ld_high", int'(loadn), 1);
    chk("run_hi", int'(running), 1);
    timer_done = 1;
    cyc(1);
    timer_done = 0;
    chk("done_run", int'(running), 0);
    chk("done_min", int'(min_data), 0);
    chk("done_cnt", int'(digit_cnt), 0);

    // Start with nothing entered does nothing.
    start = 1;
    cyc(2);
    start = 0;
    chk("empty_st", int'(loadn), 1);

    // Bouncing key then a steady hold.
    repeat (5) begin
      keypad = 10'h004; cyc(2);
      keypad = 10'h000; cyc(2);
    end
    chk("bounce", int'(digit_cnt), 0);
    keypad = 10'h004;
    cyc(DB);
    chk("hold_pre", int'(digit_cnt), 0);
    cyc(1);
    chk("hold_cnt", int'(digit_cnt), 1);
    chk("hold_dig", int'(secs_data), 2);
    cyc(6);
    keypad = '0;
    cyc(6);
    chk("one_dig", int'(digit_cnt), 1);
    pulse_clear();

    // Tens digit 7 is rejected, a new digit recovers.
    press(0, 6, 6);
    press(7, 6, 6);
    press(5, 6, 6);
    start = 1;
    cyc(1);
    start = 0;
    chk("rej_err", int'(entry_err), 1);
    chk("rej_ld", int'(loadn), 1);
    cyc(2);
    chk("err_hold", int'(entry_err), 1);
    press(1, 6, 6);
    chk("rec_err", int'(entry_err), 0);
    chk("rec_min", int'(min_data), 7);
    chk("rec_tens", int'(tens_data), 5);
    chk("rec_secs", int'(secs_data), 1);
    pulse_clear();

    // Fourth digit ignored; clear beats start.
    press(1, 6, 6);
    press(2, 6, 6);
    press(3, 6, 6);
    press(4, 6, 6);
    chk("f_min", int'(min_data), 1);
    chk("f_secs", int'(secs_data), 3);
    chk("f_cnt", int'(digit_cnt), 3);
    start = 1; clear = 1;
    cyc(1);
    start = 0; clear = 0;
    chk("sc_cnt", int'(digit_cnt), 0);
    chk("sc_ld", int'(loadn), 1);
    cyc(1);

    // timer_done during the load cycle is ignored.
    press(2, 6, 6);
    press(4, 6, 6);
    press(5, 6, 6);
    start = 1;
    cyc(1);
    start = 0; timer_done = 1;
    cyc(1);
    chk("td_load", int'(running), 1);
    cyc(1);
    timer_done = 0;
    chk("td_run", int'(running), 0);

    // Asynchronous reset in the middle of a load strobe.
    press(2, 6, 6);
    press(4, 6, 6);
    press(5, 6, 6);
    start = 1;
    cyc(1);
    start = 0;
    chk("pre_rst", int'(loadn), 0);
    #2;
    keypad = 10'h002;
    clrn = 0;
    #1;
    chk("arst_ld", int'(loadn), 1);
    chk("arst_min", int'(min_data), 0);
    chk("arst_cnt", int'(digit_cnt), 0);
    cyc(1);
    clrn = 1;
    cyc(DB);
    chk("rl_pre", int'(digit_cnt), 0);
    cyc(1);
    chk("rl_cnt", int'(digit_cnt), 1);
    chk("rl_dig", int'(secs_data), 1);
    keypad = '0;
    cyc(6);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
